alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl_if.sv | 56 +++++
 rtl/alu_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: request/response handshake and ALU-core drive/result bundle
// for the alu_seq_ctrl sequencer. The slave modport is the sequencer side.
interface alu_seq_ctrl_if #(
    parameter int unsigned n = 32
);
    // Operation request
    logic             req_valid;
    logic             req_ready;
    logic [2*n-1:0]   req_a;
    logic [2*n-1:0]   req_b;
    logic [3:0]       req_S;
    logic             req_M;
    logic             req_Cin;
    logic             req_wide;

    // Drive toward the ALU core
    logic [n-1:0]     alu_opA;
    logic [n-1:0]     alu_opB;
    logic [3:0]       alu_S;
    logic             alu_M;
    logic             alu_Cin;

    // Combinational results from the ALU core
    logic [n-1:0]     alu_DO;
    logic             alu_C;
    logic             alu_V;
    logic             alu_N;
    logic             alu_Z;

    // Result handshake
    logic             rsp_valid;
    logic             rsp_ready;
    logic [2*n-1:0]   rsp_DO;
    logic             rsp_C;
    logic             rsp_V;
    logic             rsp_N;
    logic             rsp_Z;

    modport slave (
        input  req_valid, req_a, req_b, req_S, req_M, req_Cin, req_wide,
        output req_ready,
        output alu_opA, alu_opB, alu_S, alu_M, alu_Cin,
        input  alu_DO, alu_C, alu_V, alu_N, alu_Z,
        output rsp_valid, rsp_DO, rsp_C, rsp_V, rsp_N, rsp_Z,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_S, req_M, req_Cin, req_wide,
        input  req_ready,
        input  alu_opA, alu_opB, alu_S, alu_M, alu_Cin,
        output alu_DO, alu_C, alu_V, alu_N, alu_Z,
        input  rsp_valid, rsp_DO, rsp_C, rsp_V, rsp_N, rsp_Z,
        output rsp_ready
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences one 2n-bit (wide) or n-bit (narrow) operation through
// an n-bit combinational ALU core, chaining the low-word carry into the high word.
// Optional feature: define ALU_SEQ_OPCNT_EN to add the 16-bit op_cnt output
// counting completed responses.
module alu_seq_ctrl #(
    parameter int unsigned n = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_seq_ctrl_if.slave     bus
`ifdef ALU_SEQ_OPCNT_EN
    ,
    output logic [15:0]       op_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        RSP
    } state_t;

    state_t          state_q;
    logic            wide_q;
    logic [n-1:0]    a_hi_q;
    logic [n-1:0]    b_hi_q;
    logic [n-1:0]    do_lo_q;
    logic            z_lo_q;

    logic [n-1:0]    alu_opA_q;
    logic [n-1:0]    alu_opB_q;
    logic [3:0]      alu_S_q;
    logic            alu_M_q;
    logic            alu_Cin_q;

    logic            rsp_valid_q;
    logic [2*n-1:0]  rsp_DO_q;
    logic            rsp_C_q;
    logic            rsp_V_q;
    logic            rsp_N_q;
    logic            rsp_Z_q;

    // Sequencer FSM; ALU drives are registered so they track the state exactly
    // (low word in LO, high word in HI, zero elsewhere).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wide_q      <= 1'b0;
            a_hi_q      <= '0;
            b_hi_q      <= '0;
            do_lo_q     <= '0;
            z_lo_q      <= 1'b0;
            alu_opA_q   <= '0;
            alu_opB_q   <= '0;
            alu_S_q     <= '0;
            alu_M_q     <= 1'b0;
            alu_Cin_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_DO_q    <= '0;
            rsp_C_q     <= 1'b0;
            rsp_V_q     <= 1'b0;
            rsp_N_q     <= 1'b0;
            rsp_Z_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        state_q   <= LO;
                        wide_q    <= bus.req_wide;
                        a_hi_q    <= bus.req_a[2*n-1:n];
                        b_hi_q    <= bus.req_b[2*n-1:n];
                        alu_opA_q <= bus.req_a[n-1:0];
                        alu_opB_q <= bus.req_b[n-1:0];
                        alu_S_q   <= bus.req_S;
                        alu_M_q   <= bus.req_M;
                        alu_Cin_q <= bus.req_Cin;
                    end
                end
                LO: begin
                    if (wide_q) begin
                        state_q   <= HI;
                        do_lo_q   <= bus.alu_DO;
                        z_lo_q    <= bus.alu_Z;
                        alu_opA_q <= a_hi_q;
                        alu_opB_q <= b_hi_q;
                        alu_Cin_q <= bus.alu_C;
                    end else begin
                        state_q     <= RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_DO_q    <= {{n{1'b0}}, bus.alu_DO};
                        rsp_C_q     <= bus.alu_C;
                        rsp_V_q     <= bus.alu_V;
                        rsp_N_q     <= bus.alu_N;
                        rsp_Z_q     <= bus.alu_Z;
                        alu_opA_q   <= '0;
                        alu_opB_q   <= '0;
                        alu_S_q     <= '0;
                        alu_M_q     <= 1'b0;
                        alu_Cin_q   <= 1'b0;
                    end
                end
                HI: begin
                    state_q     <= RSP;
                    rsp_valid_q <= 1'b1;
                    rsp_DO_q    <= {bus.alu_DO, do_lo_q};
                    rsp_C_q     <= bus.alu_C;
                    rsp_V_q     <= bus.alu_V;
                    rsp_N_q     <= bus.alu_N;
                    rsp_Z_q     <= z_lo_q & bus.alu_Z;
                    alu_opA_q   <= '0;
                    alu_opB_q   <= '0;
                    alu_S_q     <= '0;
                    alu_M_q     <= 1'b0;
                    alu_Cin_q   <= 1'b0;
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_OPCNT_EN
    logic [15:0] op_cnt_q;

    // Completed-response counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q <= '0;
        end else if (state_q == RSP && bus.rsp_ready) begin
            op_cnt_q <= op_cnt_q + 16'd1;
        end
    end

    assign op_cnt = op_cnt_q;
`endif

    // Ready is gated by rst_n so it reads 0 throughout reset and 1 right after release
    assign bus.req_ready = rst_n && (state_q == IDLE);
    assign bus.alu_opA   = alu_opA_q;
    assign bus.alu_opB   = alu_opB_q;
    assign bus.alu_S     = alu_S_q;
    assign bus.alu_M     = alu_M_q;
    assign bus.alu_Cin   = alu_Cin_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_DO    = rsp_DO_q;
    assign bus.rsp_C     = rsp_C_q;
    assign bus.rsp_V     = rsp_V_q;
    assign bus.rsp_N     = rsp_N_q;
    assign bus.rsp_Z     = rsp_Z_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed + randomized bench for alu_seq_ctrl (n=32) with a
// small combinational ALU core attached and a 64-bit arithmetic reference model.
module tb_alu_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    alu_seq_ctrl_if #(.n(32)) bus ();

`ifdef ALU_SEQ_OPCNT_EN
    logic [15:0] op_cnt;
`endif

    alu_seq_ctrl #(.n(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ALU_SEQ_OPCNT_EN
        ,
        .op_cnt(op_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Attached ALU core: M=1 S=1001 add, M=1 S=0110 subtract (A + ~B + Cin),
    // M=0 logic ops selected by S[1:0] (AND, OR, XOR, NOT A).
    logic [32:0] core_s;
    logic [31:0] core_do;
    logic        core_c;
    logic        core_v;
    always_comb begin
        core_s  = '0;
        core_do = '0;
        core_c  = 1'b0;
        core_v  = 1'b0;
        if (bus.alu_M) begin
            if (bus.alu_S == 4'b1001) begin
                core_s  = {1'b0, bus.alu_opA} + {1'b0, bus.alu_opB} + {32'd0, bus.alu_Cin};
                core_do = core_s[31:0];
                core_c  = core_s[32];
                core_v  = (bus.alu_opA[31] == bus.alu_opB[31]) && (core_do[31] != bus.alu_opA[31]);
            end else if (bus.alu_S == 4'b0110) begin
                core_s  = {1'b0, bus.alu_opA} + {1'b0, ~bus.alu_opB} + {32'd0, bus.alu_Cin};
                core_do = core_s[31:0];
                core_c  = core_s[32];
                core_v  = (bus.alu_opA[31] != bus.alu_opB[31]) && (core_do[31] != bus.alu_opA[31]);
            end
        end else begin
            case (bus.alu_S[1:0])
                2'd0:    core_do = bus.alu_opA & bus.alu_opB;
                2'd1:    core_do = bus.alu_opA | bus.alu_opB;
                2'd2:    core_do = bus.alu_opA ^ bus.alu_opB;
                default: core_do = ~bus.alu_opA;
            endcase
        end
        bus.alu_DO = core_do;
        bus.alu_C  = core_c;
        bus.alu_V  = core_v;
        bus.alu_N  = core_do[31];
        bus.alu_Z  = (core_do == 32'd0);
    end

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned ops_done = 0;

    // Whole-operation reference: returns {C,V,N,Z,DO[63:0]} computed at full width
    function automatic logic [67:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                           input logic [3:0] s, input logic m,
                                           input logic cin, input logic wide);
        logic [63:0] aa, bb, r;
        logic [64:0] full;
        logic        c, v;
        int unsigned top;
        top  = wide ? 63 : 31;
        aa   = wide ? a : {32'd0, a[31:0]};
        bb   = wide ? b : {32'd0, b[31:0]};
        c    = 1'b0;
        v    = 1'b0;
        r    = '0;
        full = '0;
        if (m && s == 4'b1001) begin
            full = {1'b0, aa} + {1'b0, bb} + {64'd0, cin};
            r    = wide ? full[63:0] : {32'd0, full[31:0]};
            c    = wide ? full[64] : full[32];
            v    = (aa[top] == bb[top]) && (r[top] != aa[top]);
        end else if (m && s == 4'b0110) begin
            full = {1'b0, aa} + {1'b0, (wide ? ~bb : {32'd0, ~bb[31:0]})} + {64'd0, cin};
            r    = wide ? full[63:0] : {32'd0, full[31:0]};
            c    = wide ? full[64] : full[32];
            v    = (aa[top] != bb[top]) && (r[top] != aa[top]);
        end else if (!m) begin
            case (s[1:0])
                2'd0:    r = aa & bb;
                2'd1:    r = aa | bb;
                2'd2:    r = aa ^ bb;
                default: r = ~aa;
            endcase
            if (!wide) r[63:32] = '0;
        end
        return {c, v, r[top], (r == 64'd0), r};
    endfunction

    function automatic logic [71:0] alu_all();
        return {2'b00, bus.alu_opA, bus.alu_opB, bus.alu_S, bus.alu_M, bus.alu_Cin};
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_junk(input logic valid);
        bus.req_valid = valid;
        bus.req_a     = {$urandom, $urandom};
        bus.req_b     = {$urandom, $urandom};
        bus.req_S     = 4'($urandom);
        bus.req_M     = 1'($urandom);
        bus.req_Cin   = 1'($urandom);
        bus.req_wide  = 1'($urandom);
    endtask

    task automatic chk_opcnt(input string tag);
`ifdef ALU_SEQ_OPCNT_EN
        chk({tag, ".op_cnt"}, 72'(op_cnt), 72'(16'(ops_done)));
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    // One full transaction from IDLE, checking every beat and holding the response for 'stall' cycles
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] s, input logic m, input logic cin,
                          input logic wide, input int unsigned stall);
        logic [67:0] exp_r, lo_r;
        exp_r = ref_op(a, b, s, m, cin, wide);
        lo_r  = ref_op(a, b, s, m, cin, 1'b0);
        chk({tag, ".idle_ready"}, 72'(bus.req_ready), 72'd1);
        chk({tag, ".idle_alu"}, alu_all(), 72'd0);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_S     = s;
        bus.req_M     = m;
        bus.req_Cin   = cin;
        bus.req_wide  = wide;
        step();
        drive_junk(1'b0);
        chk({tag, ".lo_alu"}, alu_all(), {2'b00, a[31:0], b[31:0], s, m, cin});
        chk({tag, ".lo_ready"}, 72'(bus.req_ready), 72'd0);
        chk({tag, ".lo_rspv"}, 72'(bus.rsp_valid), 72'd0);
        if (wide) begin
            step();
            chk({tag, ".hi_alu"}, alu_all(), {2'b00, a[63:32], b[63:32], s, m, lo_r[67]});
            chk({tag, ".hi_rspv"}, 72'(bus.rsp_valid), 72'd0);
        end
        step();
        chk({tag, ".rspv"}, 72'(bus.rsp_valid), 72'd1);
        chk({tag, ".rsp_do"}, 72'(bus.rsp_DO), 72'(exp_r[63:0]));
        chk({tag, ".rsp_flags"}, 72'({bus.rsp_C, bus.rsp_V, bus.rsp_N, bus.rsp_Z}), 72'(exp_r[67:64]));
        chk({tag, ".rsp_alu"}, alu_all(), 72'd0);
        for (int unsigned i = 0; i < stall; i++) begin
            drive_junk(1'b1);
            step();
            chk({tag, ".hold_v"}, 72'(bus.rsp_valid), 72'd1);
            chk({tag, ".hold_do"}, {bus.rsp_C, bus.rsp_V, bus.rsp_N, bus.rsp_Z, bus.rsp_DO},
                72'(exp_r));
            chk({tag, ".hold_ready"}, 72'(bus.req_ready), 72'd0);
            chk_opcnt({tag, ".hold"});
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        ops_done++;
        chk({tag, ".done_v"}, 72'(bus.rsp_valid), 72'd0);
        chk({tag, ".done_ready"}, 72'(bus.req_ready), 72'd1);
        chk_opcnt({tag, ".done"});
    endtask

    initial begin
        logic [63:0] ra, rb;
        logic [3:0]  rs;
        logic        rm;
        int unsigned pick;

        rst_n = 1'b0;
        drive_junk(1'b0);
        bus.rsp_ready = 1'b0;
        #3;
        chk("rst.ready", 72'(bus.req_ready), 72'd0);
        chk("rst.rspv", 72'(bus.rsp_valid), 72'd0);
        chk("rst.rsp", {bus.rsp_C, bus.rsp_V, bus.rsp_N, bus.rsp_Z, bus.rsp_DO}, 72'd0);
        chk("rst.alu", alu_all(), 72'd0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rel.ready", 72'(bus.req_ready), 72'd1);
        chk_opcnt("rel");
        step();

        // Narrow add with signed overflow
        run_op("narrow_add", 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF,
               4'b1001, 1'b1, 1'b0, 1'b0, 0);
        // Wide add: low-word carry must reach the high word
        run_op("wide_carry", 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001,
               4'b1001, 1'b1, 1'b0, 1'b1, 0);
        // Wide zero: both words zero
        run_op("wide_zero", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               4'b0110, 1'b1, 1'b1, 1'b1, 0);
        // High word zero, low word nonzero
        run_op("wide_lozero", 64'h0000_0001_0000_0005, 64'h0000_0001_0000_0002,
               4'b0110, 1'b1, 1'b1, 1'b1, 0);
        // Backpressure with junk requests while busy
        run_op("bp_wide", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
               4'b1001, 1'b1, 1'b1, 1'b1, 5);
        run_op("bp_narrow", 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000,
               4'b1001, 1'b1, 1'b0, 1'b0, 5);

        // Reset during HI: aborted without response
        bus.req_valid = 1'b1;
        bus.req_a     = 64'h0000_0000_FFFF_FFFF;
        bus.req_b     = 64'h0000_0000_0000_0001;
        bus.req_S     = 4'b1001;
        bus.req_M     = 1'b1;
        bus.req_Cin   = 1'b0;
        bus.req_wide  = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        chk("midhi.cin", 72'(bus.alu_Cin), 72'd1);
        rst_n = 1'b0;
        #1;
        chk("midhi.rspv", 72'(bus.rsp_valid), 72'd0);
        chk("midhi.alu", alu_all(), 72'd0);
        chk("midhi.ready", 72'(bus.req_ready), 72'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("midhi.rel_ready", 72'(bus.req_ready), 72'd1);
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            chk("midhi.no_rsp", 72'(bus.rsp_valid), 72'd0);
        end
        bus.rsp_ready = 1'b0;
        chk_opcnt("midhi");

        // Randomized operations
        for (int unsigned i = 0; i < 40; i++) begin
            pick = $urandom_range(0, 5);
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            if (pick == 0) begin
                rs = 4'b1001;
                rm = 1'b1;
            end else if (pick == 1) begin
                rs = 4'b0110;
                rm = 1'b1;
            end else begin
                rs = 4'(pick - 2);
                rm = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) rb = ra;
            run_op($sformatf("rnd%0d", i), ra, rb, rs, rm, 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
